// File: rtl/keypad_pkg.sv
// Shared types and defaults for the keypad row debouncer.
package keypad_pkg;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_WAIT,
        DB_HELD,
        DB_RELEASE_WAIT
    } db_state_t;

    localparam int DB_STABLE_DEFAULT = 16;
    localparam int DB_SYNC_DEFAULT   = 2;

    // Counter must hold the larger of the stability and repeat thresholds.
    function automatic int db_cnt_width(input int stable, input int rpt);
        int m;
        m = (stable > rpt) ? stable : rpt;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One keypad row line: input synchroniser, bounce filter FSM, optional auto-repeat.
module debounce_channel
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES   = DB_SYNC_DEFAULT,
    parameter int STABLE_CYCLES = DB_STABLE_DEFAULT,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = db_cnt_width(STABLE_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_channel: STABLE_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 0 || REPEAT_CYCLES == 1) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_CYCLES must be 0 or >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   s;
    db_state_t              state;
    logic [CW-1:0]          cnt;

    assign s = sync_pipe[SYNC_STAGES-1];

    // Shift the asynchronous line through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], raw};
    end

    // Filter FSM; pulses default low and are raised only on the accepting cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= DB_IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                DB_IDLE: begin
                    if (s) begin
                        state <= DB_PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!s) begin
                        state <= DB_IDLE;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= DB_HELD;
                        cnt         <= '0;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DB_HELD: begin
                    if (!s) begin
                        state <= DB_RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (cnt == REPEAT_LAST) begin
                            cnt         <= '0;
                            press_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                DB_RELEASE_WAIT: begin
                    // A glitch back to 1 returns to HELD and restarts the repeat timer.
                    if (s) begin
                        state <= DB_HELD;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state         <= DB_IDLE;
                        cnt           <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= DB_IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/row_debouncer_array.sv
// N independent row-line debouncers plus a combined "any key held" flag.
module row_debouncer_array
    import keypad_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = DB_SYNC_DEFAULT,
    parameter int STABLE_CYCLES = DB_STABLE_DEFAULT,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            any_held
);

    if (N_CH < 1) begin : g_bad_nch
        $error("row_debouncer_array: N_CH must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .raw          (raw_in[i]),
            .level        (level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end

    // Levels are registered, so the OR adds no extra latency.
    assign any_held = |level;

endmodule
